// File: rtl/scaler_linebuf_ctrl.sv
// Ping-pong line buffer sequencer for ram_scaler: fills one bank while replaying the other with integer h/v repeat.
// First output 2 cycles after a line closes; input stalls while the write bank is full, output holds while out_ready=0.
module scaler_linebuf_ctrl #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_eol,
  input  logic [2:0]            cfg_hrep,
  input  logic [2:0]            cfg_vrep,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_eol,
  output logic                  ovf_err
);
  localparam int PTR_W = ADDR_WIDTH - 1;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t state, state_nxt;

  logic [1:0]            full, full_nxt;
  logic                  wr_bank, rd_bank;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [ADDR_WIDTH-1:0] len0, len1, cur_len;
  logic [2:0]            hrep, vrep, hcnt, vcnt;
  logic                  wr_close, last_h, last_p, last_v;
  logic                  load, h_step, p_step, v_step, rel_bank;

  assign in_ready    = rst_n & ~full[wr_bank];
  assign ram_wr_en   = in_valid & in_ready;
  assign ram_wr_addr = {wr_bank, wr_ptr};
  assign ram_wr_data = rst_n ? in_data : '0;
  // A line closes on eol or when the bank is exhausted (all-ones pointer).
  assign wr_close    = ram_wr_en & (in_eol | (&wr_ptr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      wr_ptr  <= '0;
      len0    <= '0;
      len1    <= '0;
      ovf_err <= 1'b0;
    end else if (ram_wr_en) begin
      if (wr_close) begin
        if (wr_bank) len1 <= {1'b0, wr_ptr} + ADDR_WIDTH'(1);
        else         len0 <= {1'b0, wr_ptr} + ADDR_WIDTH'(1);
        wr_bank <= ~wr_bank;
        wr_ptr  <= '0;
        if (!in_eol) ovf_err <= 1'b1;
      end else begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
    end
  end

  // Close and release always target different banks, so both can apply in one cycle.
  always_comb begin
    full_nxt = full;
    if (wr_close) full_nxt[wr_bank] = 1'b1;
    if (rel_bank) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) full <= 2'b00;
    else        full <= full_nxt;
  end

  assign last_h = (hcnt == hrep - 3'd1);
  assign last_p = ({1'b0, rd_ptr} == cur_len - ADDR_WIDTH'(1));
  assign last_v = (vcnt == vrep - 3'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    h_step    = 1'b0;
    p_step    = 1'b0;
    v_step    = 1'b0;
    rel_bank  = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          load      = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = HOLD;
      HOLD: begin
        if (out_ready) begin
          if (!last_h) begin
            h_step = 1'b1;
          end else if (!last_p) begin
            p_step    = 1'b1;
            state_nxt = FETCH;
          end else if (!last_v) begin
            v_step    = 1'b1;
            state_nxt = FETCH;
          end else begin
            rel_bank  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank <= 1'b0;
      rd_ptr  <= '0;
      cur_len <= '0;
      hrep    <= 3'd1;
      vrep    <= 3'd1;
      hcnt    <= '0;
      vcnt    <= '0;
    end else begin
      if (load) begin
        cur_len <= rd_bank ? len1 : len0;
        hrep    <= (cfg_hrep == 3'd0) ? 3'd1 : cfg_hrep;
        vrep    <= (cfg_vrep == 3'd0) ? 3'd1 : cfg_vrep;
        rd_ptr  <= '0;
        hcnt    <= '0;
        vcnt    <= '0;
      end
      if (h_step) hcnt <= hcnt + 3'd1;
      if (p_step) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
        hcnt   <= '0;
      end
      if (v_step) begin
        vcnt   <= vcnt + 3'd1;
        rd_ptr <= '0;
        hcnt   <= '0;
      end
      if (rel_bank) rd_bank <= ~rd_bank;
    end
  end

  // RAM output is used directly; the address stays fixed through HOLD so the data is stable.
  assign ram_rd_addr = {rd_bank, rd_ptr};
  assign out_valid   = (state == HOLD);
  assign out_data    = out_valid ? ram_rd_data : '0;
  assign out_eol     = out_valid & last_h & last_p;

endmodule

// File: tb/tb_scaler_linebuf_ctrl.sv
// Bench for scaler_linebuf_ctrl: directed scenarios plus randomized traffic, checked against a
// line-level replay model, with a behavioural 1-cycle-latency RAM.
module tb_scaler_linebuf_ctrl;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int LINE_MAX = 2 ** (AW - 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          in_eol = 1'b0;
  logic [2:0]    cfg_hrep = 3'd1;
  logic [2:0]    cfg_vrep = 3'd1;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_wr_data;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_rd_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_eol;
  logic          ovf_err;

  always #5 clk = ~clk;

  scaler_linebuf_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_eol(in_eol),
    .cfg_hrep(cfg_hrep), .cfg_vrep(cfg_vrep),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_eol(out_eol),
    .ovf_err(ovf_err)
  );

  logic [DW-1:0] mem [0:2**AW-1];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  // Monitor: records accepted input/output beats and flags output changes during a stall.
  int         cyc = 0;
  int         stab_err = 0;
  logic [8:0] acc_q[$];
  logic [8:0] obs_q[$];
  int         obs_cyc[$];
  logic       stall_q = 1'b0;
  logic [8:0] stall_beat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q <= 1'b0;
    end else begin
      if (stall_q && !(out_valid && {out_eol, out_data} == stall_beat)) stab_err <= stab_err + 1;
      stall_q    <= out_valid & ~out_ready;
      stall_beat <= {out_eol, out_data};
      if (in_valid && in_ready) acc_q.push_back({in_eol, in_data});
      if (out_valid && out_ready) begin
        obs_q.push_back({out_eol, out_data});
        obs_cyc.push_back(cyc);
      end
    end
  end

  int         checks = 0;
  int         errors = 0;
  int         acc_base = 0;
  int         obs_base = 0;
  logic [8:0] exp_q[$];
  bit         exp_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_phase();
    acc_base = acc_q.size();
    obs_base = obs_q.size();
  endtask

  // Reference: cut accepted pixels into lines, then emit each line vrep times, each pixel hrep times.
  task automatic build_exp(input int hr_cfg, input int vr_cfg);
    int hr, vr;
    logic [7:0] line[$];
    hr = (hr_cfg == 0) ? 1 : hr_cfg;
    vr = (vr_cfg == 0) ? 1 : vr_cfg;
    exp_q.delete();
    for (int i = acc_base; i < acc_q.size(); i++) begin
      line.push_back(acc_q[i][7:0]);
      if (acc_q[i][8] || line.size() == LINE_MAX) begin
        if (!acc_q[i][8]) exp_ovf = 1'b1;
        for (int v = 0; v < vr; v++)
          for (int p = 0; p < line.size(); p++)
            for (int h = 0; h < hr; h++)
              exp_q.push_back({(p == line.size() - 1 && h == hr - 1), line[p]});
        line.delete();
      end
    end
  endtask

  task automatic send_px(input logic [7:0] d, input logic e);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_eol   = e;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
      n++;
      if (!done && n > 20000) begin
        check("send_timeout", 0, 1);
        done = 1'b1;
      end
    end
  endtask

  task automatic drain_and_compare(input string tag, input int hr, input int vr);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    build_exp(hr, vr);
    n = 0;
    while (obs_q.size() - obs_base < exp_q.size() && n < 20000) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_count"}, obs_q.size() - obs_base, exp_q.size());
    for (int i = 0; i < exp_q.size() && obs_base + i < obs_q.size(); i++)
      check({tag, "_beat"}, obs_q[obs_base + i], exp_q[i]);
    check({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
    check({tag, "_stable"}, stab_err, 0);
    check({tag, "_ovf"}, ovf_err, exp_ovf);
  endtask

  task automatic random_phase(input int ncyc);
    int  llen;
    bit  acc;
    llen = 0;
    in_valid = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (!in_valid && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        in_eol   = (llen >= 15) || ($urandom_range(0, 5) == 0);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        llen = in_eol ? 0 : llen + 1;
        in_valid = 1'b0;
      end
    end
    out_ready = 1'b1;
    if (in_valid) send_px(in_data, 1'b1);
    else if (llen != 0) send_px(8'($urandom), 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    in_valid = 1'b0;
    exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hr, vr;
    // Reset state, with a pixel offered while held in reset.
    in_valid = 1'b1;
    in_data  = 8'hAA;
    #3;
    check("rst_out", {in_ready, ram_wr_en, ram_wr_data, out_valid, out_data, out_eol, ovf_err}, 0);
    check("rst_addr", {ram_wr_addr, ram_rd_addr}, 0);
    reset_dut();
    check("rst_rdy", in_ready, 1);

    // 1: hrep=1, vrep=1, latency and one-cycle bubble between pixels.
    cfg_hrep = 3'd1; cfg_vrep = 3'd1; out_ready = 1'b1;
    begin_phase();
    send_px(8'd10, 1'b0); send_px(8'd11, 1'b0); send_px(8'd12, 1'b0); send_px(8'd13, 1'b1);
    in_valid = 1'b0;
    check("t1_lat0", out_valid, 0);
    @(posedge clk); #1; check("t1_lat1", out_valid, 0);
    @(posedge clk); #1; check("t1_first", {out_valid, out_data}, {1'b1, 8'd10});
    @(posedge clk); #1; check("t1_bubble", out_valid, 0);
    @(posedge clk); #1; check("t1_second", {out_valid, out_data}, {1'b1, 8'd11});
    drain_and_compare("t1", 1, 1);
    for (int i = 0; i < 3; i++)
      check("t1_gap", obs_cyc[obs_base + i + 1] - obs_cyc[obs_base + i], 2);

    // 2: hrep=2, vrep=2.
    cfg_hrep = 3'd2; cfg_vrep = 3'd2;
    begin_phase();
    send_px(8'hA0, 1'b0); send_px(8'hA1, 1'b1);
    drain_and_compare("t2", 2, 2);

    // 3: stall in HOLD of pixel 11.
    cfg_hrep = 3'd1; cfg_vrep = 3'd1;
    begin_phase();
    send_px(8'd10, 1'b0); send_px(8'd11, 1'b0); send_px(8'd12, 1'b0); send_px(8'd13, 1'b1);
    in_valid = 1'b0;
    n = 0;
    while (!(out_valid && out_data == 8'd11) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("t3_found", {out_valid, out_data}, {1'b1, 8'd11});
    out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("t3_hold", {out_valid, out_data}, {1'b1, 8'd11});
    end
    drain_and_compare("t3", 1, 1);

    // 4: both banks fill; third line waits for line 1 to finish replaying.
    out_ready = 1'b0;
    begin_phase();
    send_px(8'd20, 1'b0); send_px(8'd21, 1'b0); send_px(8'd22, 1'b0); send_px(8'd23, 1'b1);
    send_px(8'd30, 1'b0); send_px(8'd31, 1'b0); send_px(8'd32, 1'b1);
    check("t4_full", in_ready, 0);
    in_valid = 1'b1; in_data = 8'd40; in_eol = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t4_blocked", {in_ready, ram_wr_en}, 0);
    out_ready = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ram_wr_en && n < 200);
    check("t4_after_line1", obs_q.size() - obs_base, 4);
    @(posedge clk); #1;
    send_px(8'd41, 1'b1);
    drain_and_compare("t4", 1, 1);

    // Randomized traffic with random repeat factors (0 means 1).
    for (int r = 0; r < 3; r++) begin
      hr = $urandom_range(0, 7);
      vr = $urandom_range(0, 7);
      cfg_hrep = 3'(hr); cfg_vrep = 3'(vr);
      begin_phase();
      random_phase(300);
      drain_and_compare("rnd", hr, vr);
    end

    // 5: overlong line is cut at LINE_MAX; next pixel starts bank 1.
    cfg_hrep = 3'd1; cfg_vrep = 3'd1; out_ready = 1'b1;
    check("t5_pre_ovf", ovf_err, 0);
    begin_phase();
    for (int i = 0; i < LINE_MAX; i++) send_px(8'(i), 1'b0);
    check("t5_ovf", ovf_err, 1);
    in_valid = 1'b1; in_data = 8'h5A; in_eol = 1'b1;
    #1;
    check("t5_addr", {ram_wr_en, ram_wr_addr}, {1'b1, 12'h800});
    send_px(8'h5A, 1'b1);
    drain_and_compare("t5", 1, 1);

    // 6: reset in the middle of replaying line 2.
    reset_dut();
    check("t6_ovf_clr", ovf_err, 0);
    begin_phase();
    send_px(8'd50, 1'b0); send_px(8'd51, 1'b0); send_px(8'd52, 1'b1);
    send_px(8'd60, 1'b0); send_px(8'd61, 1'b0); send_px(8'd62, 1'b1);
    in_valid = 1'b0;
    n = 0;
    while (!(out_valid && obs_q.size() - obs_base >= 3) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_line2", {out_valid, out_data}, {1'b1, 8'd60});
    in_valid = 1'b1; in_data = 8'd77; in_eol = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_out", {out_valid, ram_wr_en, in_ready, out_eol, out_data}, 0);
    check("t6_rst_addr", {ram_wr_addr, ram_rd_addr}, 0);
    in_valid = 1'b0;
    exp_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_rdy", in_ready, 1);
    begin_phase();
    send_px(8'd70, 1'b0); send_px(8'd71, 1'b1);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("t6_bank0", {out_valid, ram_rd_addr[AW-1], out_data}, {1'b1, 1'b0, 8'd70});
    drain_and_compare("t6", 1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
